// File: rtl/cast_req_arbiter.sv
// -----------------------------------------------------------------------------
// cast_req_arbiter
//
// Purpose:
//   Round-robin arbiter that shares one 4-bit -> 8-bit cast unit among NREQ
//   operand producers. The cast unit supports four operations:
//     00 zero-extend, 01 sign-extend, 10 negate, 11 absolute value.
//   The winning request is cast and written into a single registered result
//   slot, tagged with the winner's index. The slot drains and refills in the
//   same edge, so a steady stream achieves one result per cycle.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   req_valid    [NREQ]    per-requester request valid
//   req_ready    [NREQ]    per-requester accept (one-hot or zero)
//   req_op       [2*NREQ]  opcode of requester i at [2i+1:2i]
//   req_data     [4*NREQ]  operand of requester i at [4i+3:4i]
//   rsp_valid    result slot holds a valid result
//   rsp_ready    consumer accepts the result
//   rsp_data     [8]       cast result
//   rsp_id       [IDW]     index of the requester that produced rsp_data
//
// Optional build macro CAST_ARB_STATS_EN adds:
//   grant_count  [16]  saturating count of grants
//   stall_count  [16]  saturating count of back-pressured cycles with
//                      pending requests
// -----------------------------------------------------------------------------
module cast_req_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [2*NREQ-1:0]   req_op,
  input  logic [4*NREQ-1:0]   req_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [7:0]          rsp_data,
  output logic [IDW-1:0]      rsp_id
`ifdef CAST_ARB_STATS_EN
  ,
  output logic [15:0]         grant_count,
  output logic [15:0]         stall_count
`endif
);

  // ---------------------------------------------------------------------------
  // Shared cast unit
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] cast8(input logic [1:0] op, input logic [3:0] a);
    logic [7:0] zx;
    logic [7:0] sx;
    logic [7:0] neg;
    zx  = {4'b0000, a};
    sx  = {{4{a[3]}}, a};
    neg = ~sx + 8'd1;           // two's complement of the sign-extended value
    case (op)
      2'b00:   cast8 = zx;
      2'b01:   cast8 = sx;
      2'b10:   cast8 = neg;
      default: cast8 = a[3] ? neg : zx;  // -8 maps to +8, fits in 8 bits
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Slot FSM and state
  // ---------------------------------------------------------------------------
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [7:0]     data_q, data_d;
  logic [IDW-1:0] id_q, id_d;

  logic           can_accept;
  logic           any_valid;
  logic           grant;

  // ---------------------------------------------------------------------------
  // Round-robin search
  //
  // The request vector is rotated so that bit 0 corresponds to ptr_q; a
  // simple lowest-set-bit priority pick then yields the first valid requester
  // at or above ptr_q with wrap. The one-hot pick is rotated back to the
  // original requester positions.
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0] rot_valid;
  logic [NREQ-1:0] seen;        // seen[k]: some rotated bit below k is set
  logic [NREQ-1:0] rot_pick;
  logic [NREQ-1:0] gnt_oh;
  logic [2*NREQ-1:0] pick_ext;

  assign rot_valid = NREQ'({req_valid, req_valid} >> ptr_q);
  assign seen[0]   = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NREQ; gi++) begin : g_seen
      assign seen[gi] = seen[gi-1] | rot_valid[gi-1];
    end
    for (gi = 0; gi < NREQ; gi++) begin : g_pick
      assign rot_pick[gi] = rot_valid[gi] & ~seen[gi];
    end
  endgenerate

  assign pick_ext = {{NREQ{1'b0}}, rot_pick} << ptr_q;
  assign gnt_oh   = pick_ext[NREQ-1:0] | pick_ext[2*NREQ-1:NREQ];

  // One-hot to index and operand selection as AND-OR chains.
  logic [IDW-1:0] idx_acc  [NREQ+1];
  logic [1:0]     op_acc   [NREQ+1];
  logic [3:0]     opd_acc  [NREQ+1];

  assign idx_acc[0] = '0;
  assign op_acc[0]  = '0;
  assign opd_acc[0] = '0;

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_sel
      assign idx_acc[gi+1] = idx_acc[gi] | (gnt_oh[gi] ? IDW'(gi) : '0);
      assign op_acc[gi+1]  = op_acc[gi]  | (req_op[2*gi +: 2]   & {2{gnt_oh[gi]}});
      assign opd_acc[gi+1] = opd_acc[gi] | (req_data[4*gi +: 4] & {4{gnt_oh[gi]}});
    end
  endgenerate

  logic [IDW-1:0] gnt_idx;
  logic [1:0]     gnt_op;
  logic [3:0]     gnt_opd;
  logic [7:0]     cast_res;

  assign gnt_idx  = idx_acc[NREQ];
  assign gnt_op   = op_acc[NREQ];
  assign gnt_opd  = opd_acc[NREQ];
  assign cast_res = cast8(gnt_op, gnt_opd);

  // ---------------------------------------------------------------------------
  // Accept / grant qualification
  // ---------------------------------------------------------------------------
  assign any_valid  = |req_valid;
  assign can_accept = (state_q == S_EMPTY) || rsp_ready;
  // Grants are suppressed in the reset cycle so nothing is handed out that
  // the reset edge would then discard.
  assign grant      = can_accept && any_valid && !rst;
  assign req_ready  = grant ? gnt_oh : '0;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: begin
        if (grant) state_d = S_FULL;
      end
      S_FULL: begin
        // A grant while FULL implies rsp_ready, so the slot refills in place.
        if (grant)          state_d = S_FULL;
        else if (rsp_ready) state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    rsp_valid = (state_q == S_FULL);
  end

  // ---------------------------------------------------------------------------
  // Result slot and round-robin pointer
  // ---------------------------------------------------------------------------
  always_comb begin
    data_d = data_q;
    id_d   = id_q;
    ptr_d  = ptr_q;
    if (grant) begin
      data_d = cast_res;
      id_d   = gnt_idx;
      ptr_d  = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= 8'h00;
      id_q   <= '0;
      ptr_q  <= '0;
    end else begin
      data_q <= data_d;
      id_q   <= id_d;
      ptr_q  <= ptr_d;
    end
  end

  assign rsp_data = data_q;
  assign rsp_id   = id_q;

`ifdef CAST_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics counters
  // ---------------------------------------------------------------------------
  logic [15:0] grant_cnt_q, grant_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stall_cycle;

  assign stall_cycle = (state_q == S_FULL) && !rsp_ready && any_valid;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (grant && (grant_cnt_q != 16'hFFFF))       grant_cnt_d = grant_cnt_q + 16'd1;
    if (stall_cycle && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q <= 16'h0000;
      stall_cnt_q <= 16'h0000;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign grant_count = grant_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cast_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cast_req_arbiter
//
// Self-checking bench for cast_req_arbiter (NREQ=4, IDW=2). A table of
// hand-derived vectors covers the directed scenarios; a random phase is
// checked against a behavioural model of the slot and round-robin pointer.
// -----------------------------------------------------------------------------
module tb_cast_req_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic             clk;
  logic             rst;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [2*NREQ-1:0] req_op;
  logic [4*NREQ-1:0] req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_data;
  logic [IDW-1:0]   rsp_id;
`ifdef CAST_ARB_STATS_EN
  logic [15:0]      grant_count;
  logic [15:0]      stall_count;
`endif

  cast_req_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef CAST_ARB_STATS_EN
    ,
    .grant_count (grant_count),
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: slot contents, occupancy and next-search position
  // ---------------------------------------------------------------------------
  bit m_full;
  int m_data;
  int m_id;
  int m_ptr;

  function automatic int cast_ref(input int op, input int a);
    int sv;
    int r;
    sv = (a >= 8) ? a - 16 : a;
    case (op)
      0:       r = a;
      1:       r = sv;
      2:       r = -sv;
      default: r = (sv < 0) ? -sv : sv;
    endcase
    return r & 255;
  endfunction

  // First valid requester at or after m_ptr, wrapping; -1 if none.
  function automatic int pick_ref(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // One clock cycle: drive inputs, check req_ready mid-cycle, clock, check slot.
  task automatic step(input logic r, input logic [NREQ-1:0] v, input logic [7:0] o,
                      input logic [15:0] d, input logic rr, input string tag,
                      output logic [NREQ-1:0] got_ready);
    int g;
    int exp_ready;
    rst       = r;
    req_valid = v;
    req_op    = o;
    req_data  = d;
    rsp_ready = rr;
    #3;
    g = (!r && (!m_full || rr)) ? pick_ref(v) : -1;
    exp_ready = (g >= 0) ? (1 << g) : 0;
    got_ready = req_ready;
    chk({tag, " model req_ready"}, int'(req_ready), exp_ready);
    @(posedge clk);
    #1;
    if (r) begin
      m_full = 0; m_data = 0; m_id = 0; m_ptr = 0;
    end else if (g >= 0) begin
      m_data = cast_ref(int'(o[2*g +: 2]), int'(d[4*g +: 4]));
      m_id   = g;
      m_full = 1;
      m_ptr  = (g + 1) % NREQ;
      $display("%s: grant id=%0d op=%0d a=0x%0h result=0x%02h", tag, g,
               int'(o[2*g +: 2]), int'(d[4*g +: 4]), m_data);
    end else if (m_full && rr) begin
      m_full = 0;
    end
    chk({tag, " model rsp_valid"}, int'(rsp_valid), int'(m_full));
    chk({tag, " model rsp_data"},  int'(rsp_data),  m_data);
    chk({tag, " model rsp_id"},    int'(rsp_id),    m_id);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic            rst;
    logic [3:0]      valid;
    logic [7:0]      op;
    logic [15:0]     data;
    logic            rr;
    logic [3:0]      exp_ready;
    logic            exp_valid;
    logic [7:0]      exp_data;
    logic [1:0]      exp_id;
  } vec_t;

  localparam int NVEC = 20;
  vec_t tbl [NVEC];

  initial begin
    logic [NREQ-1:0] got;
    string tag;

    // reset, then requester 0 sign-extends 0xA
    tbl[0]  = '{1'b1, 4'h0, 8'h00, 16'h0000, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0};
    tbl[1]  = '{1'b0, 4'h1, 8'h01, 16'h000A, 1'b1, 4'h1, 1'b1, 8'hFA, 2'd0};
    tbl[2]  = '{1'b0, 4'h0, 8'h00, 16'h0000, 1'b1, 4'h0, 1'b0, 8'hFA, 2'd0};
    // operand 0x8 through all four ops back-to-back
    tbl[3]  = '{1'b0, 4'h1, 8'h00, 16'h0008, 1'b1, 4'h1, 1'b1, 8'h08, 2'd0};
    tbl[4]  = '{1'b0, 4'h1, 8'h01, 16'h0008, 1'b1, 4'h1, 1'b1, 8'hF8, 2'd0};
    tbl[5]  = '{1'b0, 4'h1, 8'h02, 16'h0008, 1'b1, 4'h1, 1'b1, 8'h08, 2'd0};
    tbl[6]  = '{1'b0, 4'h1, 8'h03, 16'h0008, 1'b1, 4'h1, 1'b1, 8'h08, 2'd0};
    // reset while FULL with requests pending, then lowest valid index wins
    tbl[7]  = '{1'b1, 4'h6, 8'hE4, 16'h3333, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0};
    tbl[8]  = '{1'b0, 4'h6, 8'hE4, 16'h3333, 1'b1, 4'h2, 1'b1, 8'h03, 2'd1};
    tbl[9]  = '{1'b1, 4'hF, 8'hE4, 16'h3333, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0};
    // all four valid, ops 00/01/10/11, operand 3: round-robin order
    tbl[10] = '{1'b0, 4'hF, 8'hE4, 16'h3333, 1'b1, 4'h1, 1'b1, 8'h03, 2'd0};
    tbl[11] = '{1'b0, 4'hF, 8'hE4, 16'h3333, 1'b1, 4'h2, 1'b1, 8'h03, 2'd1};
    tbl[12] = '{1'b0, 4'hF, 8'hE4, 16'h3333, 1'b1, 4'h4, 1'b1, 8'hFD, 2'd2};
    tbl[13] = '{1'b0, 4'hF, 8'hE4, 16'h3333, 1'b1, 4'h8, 1'b1, 8'h03, 2'd3};
    tbl[14] = '{1'b0, 4'hF, 8'hE4, 16'h3333, 1'b1, 4'h1, 1'b1, 8'h03, 2'd0};
    // back-pressure for 3 cycles, then requester 1 granted as ready rises
    tbl[15] = '{1'b0, 4'h6, 8'hE4, 16'h3333, 1'b0, 4'h0, 1'b1, 8'h03, 2'd0};
    tbl[16] = '{1'b0, 4'h6, 8'hE4, 16'h3333, 1'b0, 4'h0, 1'b1, 8'h03, 2'd0};
    tbl[17] = '{1'b0, 4'h6, 8'hE4, 16'h3333, 1'b0, 4'h0, 1'b1, 8'h03, 2'd0};
    tbl[18] = '{1'b0, 4'h6, 8'hE4, 16'h33C3, 1'b1, 4'h2, 1'b1, 8'hFC, 2'd1};
    tbl[19] = '{1'b0, 4'h0, 8'hE4, 16'h3333, 1'b1, 4'h0, 1'b0, 8'hFC, 2'd1};

    rst = 1'b1; req_valid = '0; req_op = '0; req_data = '0; rsp_ready = 1'b0;
    m_full = 0; m_data = 0; m_id = 0; m_ptr = 0;
    @(posedge clk);
    #1;

    for (int n = 0; n < NVEC; n++) begin
      tag = $sformatf("vec%0d", n);
      step(tbl[n].rst, tbl[n].valid, tbl[n].op, tbl[n].data, tbl[n].rr, tag, got);
      chk({tag, " req_ready"}, int'(got),       int'(tbl[n].exp_ready));
      chk({tag, " rsp_valid"}, int'(rsp_valid), int'(tbl[n].exp_valid));
      chk({tag, " rsp_data"},  int'(rsp_data),  int'(tbl[n].exp_data));
      chk({tag, " rsp_id"},    int'(rsp_id),    int'(tbl[n].exp_id));
    end

    // -------------------------------------------------------------------------
    // Random traffic against the model, with occasional resets
    // -------------------------------------------------------------------------
    for (int n = 0; n < 400; n++) begin
      logic            r;
      logic [NREQ-1:0] v;
      logic            rr;
      r  = ($urandom_range(0, 39) == 0);
      v  = NREQ'($urandom);
      rr = ($urandom_range(0, 3) != 0);
      step(r, v, 8'($urandom), 16'($urandom), rr, $sformatf("rnd%0d", n), got);
    end

`ifdef CAST_ARB_STATS_EN
    // -------------------------------------------------------------------------
    // Statistics: 5 grants then 2 back-pressured cycles with requests pending
    // -------------------------------------------------------------------------
    step(1'b1, 4'h0, 8'h00, 16'h0000, 1'b1, "st_rst", got);
    for (int n = 0; n < 5; n++)
      step(1'b0, 4'h1, 8'h01, 16'h0005, 1'b1, $sformatf("st_g%0d", n), got);
    for (int n = 0; n < 2; n++)
      step(1'b0, 4'h2, 8'h01, 16'h0050, 1'b0, $sformatf("st_s%0d", n), got);
    chk("grant_count", int'(grant_count), 5);
    chk("stall_count", int'(stall_count), 2);
    step(1'b1, 4'h2, 8'h00, 16'h0000, 1'b1, "st_rst2", got);
    chk("grant_count after rst", int'(grant_count), 0);
    chk("stall_count after rst", int'(stall_count), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cast_req_arbiter.md
Name: cast_req_arbiter

Overview:
- Shares one 4-bit to 8-bit signed-cast unit among NREQ requesters.
- The unit supports zero-extend, sign-extend, negate and absolute value.
- Arbitration is round-robin. Each requester side uses a valid/ready handshake.
- The result path is a single registered output slot, tagged with the winning requester's index.
- The block sits between per-lane operand producers and a shared result consumer in the cast/extension datapath.

Parameters:
- NREQ, 4: number of requesters, 2..16.
- IDW, 2: width of the requester-index tag; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_op  input  2*NREQ  opcode for requester i at bits [2i+1:2i].
- req_data  input  4*NREQ  4-bit operand for requester i at bits [4i+3:4i].
- rsp_valid  output  1  result slot holds a valid result.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  8  cast result.
- rsp_id  output  IDW  index of the requester that produced rsp_data.

Behaviour:
- Opcodes, with a = 4-bit operand and s = {{4{a[3]}},a}:
  - 00 zero-extend: {4'b0,a}.
  - 01 sign-extend: s.
  - 10 negate: (-s) mod 256.
  - 11 absolute value: a[3] ? (-s) mod 256 : {4'b0,a}.
- All arithmetic is 8-bit two's complement. a=4'b1000 gives 0x08 for op 10 and for op 11; there is no overflow case.
- Output slot FSM, two states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- Slot open condition (can_accept): state==EMPTY, or state==FULL && rsp_ready.
- Grant:
  - When can_accept and any req_valid is set, grant the first valid requester searching upward (with wrap) from ptr.
  - req_ready[g]=1 combinationally in that cycle; all other bits are 0.
  - req_ready is 0 for every requester when can_accept is 0.
  - req_ready never depends on req_valid of the same requester except through the grant search.
- Accept edge (a grant occurred):
  - rsp_data <= cast(op_g, data_g); rsp_id <= g; state <= FULL; ptr <= (g+1) mod NREQ.
- Drain without new grant: FULL && rsp_ready && no valid request, then state <= EMPTY; rsp_data and rsp_id hold their values.
- Simultaneous drain and grant: the new result replaces the old one in the same edge. Throughput is one result per cycle; latency from accept to rsp_valid is 1 cycle.
- Back-pressure:
  - FULL && !rsp_ready: rsp_data, rsp_id and rsp_valid hold stable; no grants.
  - ptr does not move while no grant occurs.
- Requesters may drop req_valid without being granted; the arbiter does not require request stability.
- Reset (any cycle, including mid-transfer):
  - state=EMPTY, rsp_valid=0, rsp_data=8'h00, rsp_id=0, ptr=0.
  - req_ready=0 during the reset cycle.
  - An in-flight result is discarded.
- Fairness: a continuously valid requester is granted within NREQ accept opportunities.

Optional Feature:
- Macro: CAST_ARB_STATS_EN.
- With the macro defined, the block adds output port grant_count (16 bits) and output port stall_count (16 bits):
  - grant_count increments on every grant.
  - stall_count increments on every cycle with state==FULL, !rsp_ready and any req_valid set.
  - Both counters saturate at 16'hFFFF and clear to 0 on rst.
- Without the macro, neither port nor any counter logic exists, and the behaviour above is otherwise identical.

Test Plan:
- Reset, then requester 0 sends op 01, data 4'hA, with rsp_ready=1 -> req_ready=4'b0001 in the request cycle; next cycle rsp_valid=1, rsp_data=8'hFA, rsp_id=0.
- Single requester, data 4'h8, ops 00/01/10/11 back-to-back, rsp_ready=1 -> rsp_data 08, F8, 08, 08 on consecutive cycles; one grant per cycle.
- All four requesters valid continuously with data 4'h3 and ops 00/01/10/11 respectively -> grants in order 0,1,2,3,0,...; rsp_data sequence 03, 03, FD, 03.
- FULL slot with rsp_ready=0 for 3 cycles while requesters 1 and 2 are valid -> req_ready=0 for all, rsp_data/rsp_id stable; when rsp_ready rises, requester 1 is granted in that same cycle.
- rst asserted while FULL with requests pending -> next cycle rsp_valid=0, rsp_data=00, ptr=0; first post-reset grant goes to the lowest-index valid requester.
- With CAST_ARB_STATS_EN: 5 grants followed by 2 back-pressured cycles with pending requests -> grant_count=5, stall_count=2; both read 0 after rst.
